pa_multi: RTL and testbench

- Multi-channel, parametrised phase accumulator for the DDS datapath. It generalises the single-channel accumulator by adding NUM_CH channels, per-channel phase offset, double-buffered (shadow/active) coherent configuration update and an optional linear frequency-sweep (chirp) mode.
- Feeds the phase-to-amplitude stage.
- Configured by the control block over a valid/ready write port.

---
 rtl/pa_pkg.sv | 23 ++
 rtl/pa_chan.sv | 142 ++++++++++++++
 rtl/pa_multi.sv | 119 +++++++++++
 tb/tb_pa_multi.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pa_pkg.sv
// ---------------------------------------------------------------------------
// pa_pkg
// Shared definitions for the multi-channel phase accumulator:
//   - cfg_addr_e : register map of the configuration write port
//   - pa_state_e : control FSM states (reset / idle / apply-commit)
// ---------------------------------------------------------------------------
package pa_pkg;

  typedef enum logic [2:0] {
    CFG_FTW   = 3'd0,
    CFG_POW   = 3'd1,
    CFG_DELTA = 3'd2,
    CFG_LIMIT = 3'd3,
    CFG_MODE  = 3'd4
  } cfg_addr_e;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_IDLE  = 2'd1,
    ST_APPLY = 2'd2
  } pa_state_e;

endpackage

// File: rtl/pa_chan.sv
// ---------------------------------------------------------------------------
// pa_chan
// One DDS phase-accumulator channel: shadow configuration registers, active
// (committed) registers, the accumulator, optional linear frequency sweep and
// the registered, offset-adjusted, truncated phase output.
//
// Ports:
//   clk, n_RST          clock, synchronous active-low reset
//   wr_ftw..wr_mode     one-hot shadow register write strobes
//   wr_data             write data (POW uses low bits, MODE uses bit 0)
//   apply               copy shadow -> active at the end of this cycle
//   sync_clr            clear the accumulator
//   phase_out           registered truncated phase
//   sweep_done          sweep has saturated at LIMIT
// ---------------------------------------------------------------------------
module pa_chan
  import pa_pkg::*;
#(
  parameter int PA_WIDTH     = 23,
  parameter int TUNE_WIDTH   = 16,
  parameter int POW_WIDTH    = 12,
  parameter int PA_OUT_WIDTH = 14
) (
  input  logic                    clk,
  input  logic                    n_RST,
  input  logic                    wr_ftw,
  input  logic                    wr_pow,
  input  logic                    wr_delta,
  input  logic                    wr_limit,
  input  logic                    wr_mode,
  input  logic [TUNE_WIDTH-1:0]   wr_data,
  input  logic                    apply,
  input  logic                    sync_clr,
  output logic [PA_OUT_WIDTH-1:0] phase_out,
  output logic                    sweep_done
);

  // Shadow (written by the control port)
  logic [TUNE_WIDTH-1:0]   sh_ftw_q, sh_ftw_d;
  logic [POW_WIDTH-1:0]    sh_pow_q, sh_pow_d;
  logic [TUNE_WIDTH-1:0]   sh_delta_q, sh_delta_d;
  logic [TUNE_WIDTH-1:0]   sh_limit_q, sh_limit_d;
  logic                    sh_mode_q, sh_mode_d;

  // Active (used by the datapath)
  logic [TUNE_WIDTH-1:0]   ftw_q, ftw_d;
  logic [POW_WIDTH-1:0]    pow_q, pow_d;
  logic [TUNE_WIDTH-1:0]   delta_q, delta_d;
  logic [TUNE_WIDTH-1:0]   limit_q, limit_d;
  logic                    mode_q, mode_d;
  logic                    done_q, done_d;

  logic [PA_WIDTH-1:0]     acc_q, acc_d;
  logic [PA_OUT_WIDTH-1:0] phase_q, phase_d;

  logic [TUNE_WIDTH:0]     sweep_sum;
  logic [PA_WIDTH-1:0]     phase_sum;

  always_comb begin
    sh_ftw_d   = sh_ftw_q;
    sh_pow_d   = sh_pow_q;
    sh_delta_d = sh_delta_q;
    sh_limit_d = sh_limit_q;
    sh_mode_d  = sh_mode_q;
    if (wr_ftw)   sh_ftw_d   = wr_data;
    if (wr_pow)   sh_pow_d   = POW_WIDTH'(wr_data);
    if (wr_delta) sh_delta_d = wr_data;
    if (wr_limit) sh_limit_d = wr_data;
    if (wr_mode)  sh_mode_d  = wr_data[0];
  end

  always_comb begin
    ftw_d   = ftw_q;
    pow_d   = pow_q;
    delta_d = delta_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    done_d  = done_q;

    // One extra bit so FTW + DELTA can never wrap below LIMIT.
    sweep_sum = {1'b0, ftw_q} + {1'b0, delta_q};

    if (apply) begin
      // Loading a fresh FTW restarts any sweep from its start value.
      ftw_d   = sh_ftw_q;
      pow_d   = sh_pow_q;
      delta_d = sh_delta_q;
      limit_d = sh_limit_q;
      mode_d  = sh_mode_q;
      done_d  = 1'b0;
    end else if (mode_q) begin
      if (sweep_sum >= {1'b0, limit_q}) begin
        ftw_d  = limit_q;
        done_d = 1'b1;
      end else begin
        ftw_d  = sweep_sum[TUNE_WIDTH-1:0];
      end
    end

    acc_d = sync_clr ? '0 : acc_q + PA_WIDTH'(ftw_q);

    // Offset is left-aligned into the accumulator width; the sum wraps.
    phase_sum = acc_q + (PA_WIDTH'(pow_q) << (PA_WIDTH - POW_WIDTH));
    phase_d   = phase_sum[PA_WIDTH-1 -: PA_OUT_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!n_RST) begin
      sh_ftw_q   <= '0;
      sh_pow_q   <= '0;
      sh_delta_q <= '0;
      sh_limit_q <= '0;
      sh_mode_q  <= 1'b0;
      ftw_q      <= '0;
      pow_q      <= '0;
      delta_q    <= '0;
      limit_q    <= '0;
      mode_q     <= 1'b0;
      done_q     <= 1'b0;
      acc_q      <= '0;
      phase_q    <= '0;
    end else begin
      sh_ftw_q   <= sh_ftw_d;
      sh_pow_q   <= sh_pow_d;
      sh_delta_q <= sh_delta_d;
      sh_limit_q <= sh_limit_d;
      sh_mode_q  <= sh_mode_d;
      ftw_q      <= ftw_d;
      pow_q      <= pow_d;
      delta_q    <= delta_d;
      limit_q    <= limit_d;
      mode_q     <= mode_d;
      done_q     <= done_d;
      acc_q      <= acc_d;
      phase_q    <= phase_d;
    end
  end

  assign phase_out  = phase_q;
  assign sweep_done = done_q;

endmodule

// File: rtl/pa_multi.sv
// ---------------------------------------------------------------------------
// pa_multi
// Multi-channel DDS phase accumulator. Holds the commit FSM, the config
// address decode and out_valid; per-channel state lives in pa_chan.
//
// Ports:
//   clk, n_RST   clock, synchronous active-low reset
//   cfg_valid    config write request; cfg_ready high only in IDLE
//   cfg_chan     target channel (out-of-range channels are ignored)
//   cfg_addr     0=FTW 1=POW 2=DELTA 3=LIMIT 4=MODE, 5-7 ignored
//   cfg_data     write data
//   commit       copy all shadow registers to active, all channels at once
//   sync_clr     clear all accumulators
//   phase_out    channel k at [k*PA_OUT_WIDTH +: PA_OUT_WIDTH]
//   out_valid    phase_out meaningful (from the 2nd edge after reset release)
//   sweep_done   per-channel sweep-reached-limit flags
// ---------------------------------------------------------------------------
module pa_multi
  import pa_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int PA_WIDTH     = 23,
  parameter int TUNE_WIDTH   = 16,
  parameter int POW_WIDTH    = 12,
  parameter int PA_OUT_WIDTH = 14,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           clk,
  input  logic                           n_RST,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [CH_W-1:0]                cfg_chan,
  input  logic [2:0]                     cfg_addr,
  input  logic [TUNE_WIDTH-1:0]          cfg_data,
  input  logic                           commit,
  input  logic                           sync_clr,
  output logic [NUM_CH*PA_OUT_WIDTH-1:0] phase_out,
  output logic                           out_valid,
  output logic [NUM_CH-1:0]              sweep_done
);

  pa_state_e state_q, state_d;
  logic      out_valid_q, out_valid_d;
  logic      wr_accept;
  logic      apply;
  logic      fld_ftw, fld_pow, fld_delta, fld_limit, fld_mode;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_IDLE;
      ST_IDLE:  if (commit) state_d = ST_APPLY;
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_RESET;
    endcase
    // Once out of RESET the FSM never returns there without n_RST,
    // which clears this flag anyway.
    out_valid_d = (state_q != ST_RESET);
  end

  always_ff @(posedge clk) begin
    if (!n_RST) begin
      state_q     <= ST_RESET;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign cfg_ready = (state_q == ST_IDLE);
  assign apply     = (state_q == ST_APPLY);
  assign wr_accept = cfg_valid && cfg_ready;
  assign out_valid = out_valid_q;

  // Reserved addresses decode to no field and are silently dropped.
  always_comb begin
    fld_ftw   = 1'b0;
    fld_pow   = 1'b0;
    fld_delta = 1'b0;
    fld_limit = 1'b0;
    fld_mode  = 1'b0;
    case (cfg_addr)
      CFG_FTW:   fld_ftw   = 1'b1;
      CFG_POW:   fld_pow   = 1'b1;
      CFG_DELTA: fld_delta = 1'b1;
      CFG_LIMIT: fld_limit = 1'b1;
      CFG_MODE:  fld_mode  = 1'b1;
      default:   ;
    endcase
  end

  // Channel indices >= NUM_CH match no instance, so such writes vanish.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    logic sel;
    assign sel = wr_accept && (cfg_chan == CH_W'(gi));

    pa_chan #(
      .PA_WIDTH     (PA_WIDTH),
      .TUNE_WIDTH   (TUNE_WIDTH),
      .POW_WIDTH    (POW_WIDTH),
      .PA_OUT_WIDTH (PA_OUT_WIDTH)
    ) u_chan (
      .clk        (clk),
      .n_RST      (n_RST),
      .wr_ftw     (sel && fld_ftw),
      .wr_pow     (sel && fld_pow),
      .wr_delta   (sel && fld_delta),
      .wr_limit   (sel && fld_limit),
      .wr_mode    (sel && fld_mode),
      .wr_data    (cfg_data),
      .apply      (apply),
      .sync_clr   (sync_clr),
      .phase_out  (phase_out[gi*PA_OUT_WIDTH +: PA_OUT_WIDTH]),
      .sweep_done (sweep_done[gi])
    );
  end

endmodule

// File: tb/tb_pa_multi.sv
module tb_pa_multi;

  localparam int NUM_CH       = 4;
  localparam int PA_WIDTH     = 23;
  localparam int TUNE_WIDTH   = 16;
  localparam int POW_WIDTH    = 12;
  localparam int PA_OUT_WIDTH = 14;
  localparam int CH_W         = 2;
  localparam int unsigned PA_MASK = (32'd1 << PA_WIDTH) - 1;

  logic                           clk = 1'b0;
  logic                           n_RST = 1'b0;
  logic                           cfg_valid = 1'b0;
  logic                           cfg_ready;
  logic [CH_W-1:0]                cfg_chan = '0;
  logic [2:0]                     cfg_addr = '0;
  logic [TUNE_WIDTH-1:0]          cfg_data = '0;
  logic                           commit = 1'b0;
  logic                           sync_clr = 1'b0;
  logic [NUM_CH*PA_OUT_WIDTH-1:0] phase_out;
  logic                           out_valid;
  logic [NUM_CH-1:0]              sweep_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pa_multi #(
    .NUM_CH       (NUM_CH),
    .PA_WIDTH     (PA_WIDTH),
    .TUNE_WIDTH   (TUNE_WIDTH),
    .POW_WIDTH    (POW_WIDTH),
    .PA_OUT_WIDTH (PA_OUT_WIDTH)
  ) dut (
    .clk        (clk),
    .n_RST      (n_RST),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_chan   (cfg_chan),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .commit     (commit),
    .sync_clr   (sync_clr),
    .phase_out  (phase_out),
    .out_valid  (out_valid),
    .sweep_done (sweep_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: register file indexed by config address
  // (0 FTW, 1 POW, 2 DELTA, 3 LIMIT, 4 MODE), integer arithmetic.
  // ------------------------------------------------------------------
  int unsigned m_sh  [NUM_CH][5];
  int unsigned m_act [NUM_CH][5];
  int unsigned m_acc [NUM_CH];
  int unsigned m_ph  [NUM_CH];
  bit          m_done[NUM_CH];
  bit          m_live;      // at least one edge seen since reset release
  bit          m_applying;  // current cycle is the commit-apply cycle
  bit          m_ov;

  function automatic bit m_ready();
    return m_live && !m_applying;
  endfunction

  task automatic model_step();
    bit ready;
    int unsigned s;
    ready = m_ready();
    if (!n_RST) begin
      for (int k = 0; k < NUM_CH; k++) begin
        for (int f = 0; f < 5; f++) begin
          m_sh[k][f]  = 0;
          m_act[k][f] = 0;
        end
        m_acc[k] = 0;
        m_ph[k]  = 0;
        m_done[k] = 1'b0;
      end
      m_live = 1'b0;
      m_applying = 1'b0;
      m_ov = 1'b0;
      return;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      m_ph[k]  = ((m_acc[k] + (m_act[k][1] << (PA_WIDTH - POW_WIDTH))) & PA_MASK)
                 >> (PA_WIDTH - PA_OUT_WIDTH);
      m_acc[k] = sync_clr ? 0 : ((m_acc[k] + m_act[k][0]) & PA_MASK);
      if (m_applying) begin
        for (int f = 0; f < 5; f++) m_act[k][f] = m_sh[k][f];
        m_done[k] = 1'b0;
      end else if (m_act[k][4] != 0) begin
        s = m_act[k][0] + m_act[k][2];
        if (s >= m_act[k][3]) begin
          m_act[k][0] = m_act[k][3];
          m_done[k] = 1'b1;
        end else begin
          m_act[k][0] = s;
        end
      end
    end
    if (ready && cfg_valid && int'(cfg_chan) < NUM_CH && cfg_addr <= 3'd4) begin
      case (cfg_addr)
        3'd1:    m_sh[cfg_chan][1] = int'(cfg_data) & ((1 << POW_WIDTH) - 1);
        3'd4:    m_sh[cfg_chan][4] = int'(cfg_data) & 1;
        default: m_sh[cfg_chan][cfg_addr] = int'(cfg_data);
      endcase
    end
    m_ov = m_live;
    m_applying = ready && commit;
    m_live = 1'b1;
  endtask

  always @(posedge clk) model_step();

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [NUM_CH*PA_OUT_WIDTH-1:0] ev;
    logic [NUM_CH-1:0] ed;
    for (int k = 0; k < NUM_CH; k++) begin
      ev[k*PA_OUT_WIDTH +: PA_OUT_WIDTH] = PA_OUT_WIDTH'(m_ph[k]);
      ed[k] = m_done[k];
    end
    check("cfg_ready", 64'(cfg_ready), 64'(m_ready()));
    check("out_valid", 64'(out_valid), 64'(m_ov));
    check("sweep_done", 64'(sweep_done), 64'(ed));
    check("phase_out", 64'(phase_out), 64'(ev));
  end

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int ch, input int addr, input int data, input bit cm);
    cfg_valid = 1'b1;
    cfg_chan  = CH_W'(ch);
    cfg_addr  = 3'(addr);
    cfg_data  = TUNE_WIDTH'(data);
    commit    = cm;
    tick();
    cfg_valid = 1'b0;
    commit    = 1'b0;
  endtask

  function automatic logic [PA_OUT_WIDTH-1:0] ph(input int k);
    return phase_out[k*PA_OUT_WIDTH +: PA_OUT_WIDTH];
  endfunction

  initial begin
    // Reset
    n_RST = 1'b0;
    tick(3);
    check("rst_phase", 64'(phase_out), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(cfg_ready), 64'd0);
    check("rst_done",  64'(sweep_done), 64'd0);
    n_RST = 1'b1;
    tick();
    check("rel_ready", 64'(cfg_ready), 64'd1);
    check("rel_valid1", 64'(out_valid), 64'd0);
    tick();
    check("rel_valid2", 64'(out_valid), 64'd1);

    // Phase offset, written in the same cycle as commit
    wr(1, 1, 'h800, 1'b1);
    check("apply_ready", 64'(cfg_ready), 64'd0);
    tick();
    check("post_apply_ready", 64'(cfg_ready), 64'd1);
    tick();
    check("pow_half_turn", 64'(ph(1)), 64'h2000);

    // Sweep 0x10 -> 0x50 in steps of 0x10 on channel 2
    wr(2, 0, 'h10, 1'b0);
    wr(2, 2, 'h10, 1'b0);
    wr(2, 3, 'h50, 1'b0);
    wr(2, 4, 1, 1'b1);
    tick();
    check("sweep_start", 64'(sweep_done[2]), 64'd0);
    tick(3);
    check("sweep_at_40", 64'(sweep_done[2]), 64'd0);
    tick();
    check("sweep_at_50", 64'(sweep_done[2]), 64'd1);
    tick(5);
    check("sweep_hold", 64'(sweep_done[2]), 64'd1);
    // Re-commit restarts the sweep
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    check("recommit_clr", 64'(sweep_done[2]), 64'd0);
    tick(3);
    check("resweep_40", 64'(sweep_done[2]), 64'd0);
    tick();
    check("resweep_50", 64'(sweep_done[2]), 64'd1);

    // Commit held two cycles: the second one falls in APPLY and is ignored
    commit = 1'b1;
    tick();
    check("hold_commit_apply", 64'(cfg_ready), 64'd0);
    tick();
    commit = 1'b0;
    check("hold_commit_idle", 64'(cfg_ready), 64'd1);

    // Coherent update: shadow writes without commit, then one commit
    for (int k = 0; k < NUM_CH; k++) wr(k, 0, 'h1234 + k * 'h2111, 1'b0);
    tick(4);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick(6);

    // Reset during APPLY loses the pending shadow write
    wr(3, 1, 'h400, 1'b1);
    n_RST = 1'b0;
    tick();
    check("rst_apply_phase", 64'(phase_out), 64'd0);
    check("rst_apply_done",  64'(sweep_done), 64'd0);
    check("rst_apply_ready", 64'(cfg_ready), 64'd0);
    n_RST = 1'b1;
    tick(2);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick(3);
    check("rst_apply_lost", 64'(phase_out), 64'd0);

    // FTW 0x100 on ch0, phase-aligned with sync_clr, run through one wrap
    wr(0, 0, 'h100, 1'b1);
    tick();
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    for (int j = 1; j <= 32771; j++) begin
      tick();
      if (j == 1)     check("wrap_j1",     64'(ph(0)), 64'd0);
      if (j == 3)     check("wrap_j3",     64'(ph(0)), 64'd1);
      if (j == 1025)  check("wrap_j1025",  64'(ph(0)), 64'd512);
      if (j == 32768) check("wrap_j32768", 64'(ph(0)), 64'h3FFF);
      if (j == 32769) check("wrap_j32769", 64'(ph(0)), 64'd0);
      if (j == 32771) check("wrap_j32771", 64'(ph(0)), 64'd1);
    end

    // sync_clr with nonzero FTW and an offset present
    wr(0, 1, 'h400, 1'b1);
    tick(3);
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    tick();
    check("sync_clr_offset", 64'(ph(0)), 64'h1000);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      n_RST     = ($urandom_range(0, 299) != 0);
      cfg_valid = $urandom_range(0, 1) == 1;
      cfg_chan  = CH_W'($urandom_range(0, NUM_CH - 1));
      cfg_addr  = 3'($urandom_range(0, 7));
      cfg_data  = ($urandom_range(0, 3) == 0) ? TUNE_WIDTH'($urandom_range(0, 'h3F))
                                              : TUNE_WIDTH'($urandom);
      commit    = ($urandom_range(0, 7) == 0);
      sync_clr  = ($urandom_range(0, 39) == 0);
      tick();
    end
    n_RST = 1'b1;
    cfg_valid = 1'b0;
    commit = 1'b0;
    sync_clr = 1'b0;
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
